// File: rtl/fact_pkg.sv
// fact_pkg: shared types and constants for the factorial sequencer
// Holds the FSM state enum, the default operand/result widths and the
// saturation value driven onto the accumulator once overflow is seen.
package fact_pkg;
   typedef enum logic [1:0] {IDLE, CHECK, MUL, DONE} fact_state_e;
   localparam int FACT_NW = 8;
   localparam int FACT_RW = 32;
   localparam logic [FACT_RW-1:0] FACT_SAT_VAL = '1;
endpackage

// File: rtl/fact_shift_mul.sv
// fact_shift_mul: sequential shift-add multiplier, RW x NW into RW+NW bits
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture a/b and start a new product
//   a, b       : multiplicand (RW bits), multiplier (NW bits)
//   busy       : product in progress, one multiplier bit per cycle, LSB first
//   last       : current cycle consumes the final multiplier bit
//   p          : running product including the current bit; final when busy&last
module fact_shift_mul import fact_pkg::*; #(
   parameter int NW = FACT_NW,
   parameter int RW = FACT_RW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [RW-1:0]    a,
   input  logic [NW-1:0]    b,
   output logic             busy,
   output logic             last,
   output logic [RW+NW-1:0] p
);
   localparam int CW = $clog2(NW + 1);
   logic [RW+NW-1:0] a_q, p_q;
   logic [NW-1:0]    b_q;
   logic [CW-1:0]    bit_q;
   logic             busy_q;
   // Exposing the sum combinationally lets the caller take the product on the last busy edge.
   assign p    = p_q + (b_q[0] ? a_q : '0);
   assign last = bit_q == CW'(NW - 1);
   assign busy = busy_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         bit_q  <= '0;
         busy_q <= 1'b0;
      end else if (load) begin
         a_q    <= {{NW{1'b0}}, a};
         b_q    <= b;
         p_q    <= '0;
         bit_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         a_q    <= a_q << 1;
         b_q    <= b_q >> 1;
         p_q    <= p;
         bit_q  <= bit_q + CW'(1);
         busy_q <= !last;
      end
   end
endmodule

// File: rtl/fact_sequencer.sv
// fact_sequencer: multi-cycle factorial engine with start/ready/done handshake
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : request, accepted only while ready=1
//   number     : operand, sampled on the accepting edge
//   ready      : high only in IDLE
//   done       : one-cycle pulse, coincides with the new result
//   result     : last factorial, held until the next done
//   overflow   : last result exceeded RW bits
// Build option: define FACT_SAT_EN to track overflow and saturate result to
// all-ones; otherwise overflow is tied 0 and result wraps modulo 2^RW.
module fact_sequencer import fact_pkg::*; #(
   parameter int NW = FACT_NW,
   parameter int RW = FACT_RW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [NW-1:0] number,
   output logic          ready,
   output logic          done,
   output logic [RW-1:0] result,
   output logic          overflow
);
   fact_state_e      state_q;
   logic [NW-1:0]    cnt_q;
   logic [RW-1:0]    acc_q, result_q;
   logic             ready_q, done_q;
   logic             mul_load, mul_busy, mul_last;
   logic [RW+NW-1:0] mul_p;
   assign mul_load = state_q == CHECK && cnt_q > NW'(1);
   fact_shift_mul #(.NW(NW), .RW(RW)) u_mul (
      .clk   (clk),
      .reset (reset),
      .load  (mul_load),
      .a     (acc_q),
      .b     (cnt_q),
      .busy  (mul_busy),
      .last  (mul_last),
      .p     (mul_p)
   );
`ifdef FACT_SAT_EN
   logic          ovf_q, ovf_d, overflow_q;
   logic [RW-1:0] acc_d;
   assign ovf_d    = ovf_q | (|mul_p[RW+NW-1:RW]);
   assign acc_d    = ovf_d ? RW'(FACT_SAT_VAL) : mul_p[RW-1:0];
   assign overflow = overflow_q;
`else
   logic [RW-1:0] acc_d;
   logic          mul_hi_unused;
   assign acc_d         = mul_p[RW-1:0];
   assign mul_hi_unused = |mul_p[RW+NW-1:RW];
   assign overflow      = 1'b0;
`endif
   assign ready  = ready_q;
   assign done   = done_q;
   assign result = result_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= RW'(1);
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         result_q   <= '0;
`ifdef FACT_SAT_EN
         ovf_q      <= 1'b0;
         overflow_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               cnt_q   <= number;
               acc_q   <= RW'(1);
               ready_q <= 1'b0;
               state_q <= CHECK;
`ifdef FACT_SAT_EN
               ovf_q   <= 1'b0;
`endif
            end
            // Outputs are registered on entry to DONE so done and result appear together.
            CHECK: if (cnt_q <= NW'(1)) begin
               state_q    <= DONE;
               done_q     <= 1'b1;
               result_q   <= acc_q;
`ifdef FACT_SAT_EN
               overflow_q <= ovf_q;
`endif
            end else begin
               state_q <= MUL;
            end
            MUL: if (mul_busy && mul_last) begin
               acc_q   <= acc_d;
               cnt_q   <= cnt_q - NW'(1);
               state_q <= CHECK;
`ifdef FACT_SAT_EN
               ovf_q   <= ovf_d;
`endif
            end
            DONE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fact_sequencer.sv
// tb_fact_sequencer: directed self-checking bench for fact_sequencer
module tb_fact_sequencer;
   logic        clk, reset, start;
   logic [7:0]  number;
   logic        ready, done, overflow;
   logic [31:0] result;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_prev = 32'd0;
`ifdef FACT_SAT_EN
   localparam logic        SAT = 1'b1;
   localparam logic [31:0] F13 = 32'hFFFF_FFFF;
   localparam logic [31:0] F255 = 32'hFFFF_FFFF;
`else
   localparam logic        SAT = 1'b0;
   localparam logic [31:0] F13 = 32'h7328_CC00;
   localparam logic [31:0] F255 = 32'h0000_0000;
`endif
   fact_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .number   (number),
      .ready    (ready),
      .done     (done),
      .result   (result),
      .overflow (overflow)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   // Cycle 0 carries the accepted start; cycle k follows the k-th edge after it.
   task automatic run_fact(input logic [7:0] n, input logic [31:0] exp_res, input logic exp_ovf,
                           input int exp_lat, input int stray, input int abort);
      int lat = -1;
      int ndone = 0;
      @(negedge clk);
      check("ready_idle", 32'(ready), 32'd1);
      start  = 1'b1;
      number = n;
      @(posedge clk);
      for (int k = 1; k <= exp_lat + 100; k++) begin
         @(negedge clk);
         start  = (k == stray);
         number = (k == stray) ? 8'd9 : 8'hA5;
         if (k == 1) check("result_held", result, exp_prev);
         if (k == abort) begin
            reset = 1'b1;
            #1;
            check("abort_ready", 32'(ready), 32'd1);
            check("abort_result", result, 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_ovf", 32'(overflow), 32'd0);
            #1 reset = 1'b0;
         end
         if (lat > 0 && k == lat + 1) check("ready_back", 32'(ready), 32'd1);
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = k;
               check("result", result, exp_res);
               check("overflow", 32'(overflow), 32'(exp_ovf));
               check("ready_in_done", 32'(ready), 32'd0);
            end
         end
      end
      start = 1'b0;
      if (abort > 0) begin
         check("abort_no_done", 32'(ndone), 32'd0);
         exp_prev = 32'd0;
      end else begin
         check("latency", 32'(lat), 32'(exp_lat));
         check("done_count", 32'(ndone), 32'd1);
         exp_prev = exp_res;
      end
   endtask
   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      number = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      run_fact(8'd0, 32'd1, 1'b0, 2, 0, 0);
      run_fact(8'd1, 32'd1, 1'b0, 2, 0, 0);
      run_fact(8'd5, 32'd120, 1'b0, 38, 0, 0);
      run_fact(8'd12, 32'h1C8C_FC00, 1'b0, 101, 0, 0);
      run_fact(8'd13, F13, SAT, 110, 0, 0);
      run_fact(8'd4, 32'd24, 1'b0, 29, 5, 0);
      run_fact(8'd255, F255, SAT, 2288, 0, 0);
      run_fact(8'd10, 32'd0, 1'b0, 83, 0, 15);
      run_fact(8'd3, 32'd6, 1'b0, 20, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fact_sequencer.md
# fact_sequencer

Multi-cycle factorial engine with a start/done handshake. It accepts an 8-bit operand `number` and computes `number!` into a 32-bit result by repeated multiplication, counting down from `number`. It shares one shift-add multiplier across all iterations. It replaces the free-running control/datapath pair at the top level, gives the consumer an explicit ready/done protocol, and reports overflow.

## Interface
Parameters:
- `NW`, 8: operand width.
- `RW`, 32: result and accumulator width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: request. Accepted only in a cycle where `ready`=1.
- `number`, input, NW: operand, sampled on the accepting edge.
- `ready`, output, 1: high only in IDLE.
- `done`, output, 1: single-cycle pulse when `result` is updated.
- `result`, output, RW: last factorial. Held until the next `done`.
- `overflow`, output, 1: last result exceeded RW bits. Updated with `done`.

## Operation
State machine: IDLE, CHECK, MUL, DONE.
- IDLE:
  - `ready`=1.
  - On `start`: `cnt`<=`number`, `acc`<=1, `ovf`<=0, go to CHECK.
- CHECK:
  - If `cnt`<=1, go to DONE.
  - Otherwise start the multiplier with operands `acc` and `cnt`, and go to MUL.
- MUL:
  - Lasts exactly NW cycles, one multiplier bit per cycle, LSB first.
  - On the last cycle: `acc`<=product[RW-1:0], `ovf`<=`ovf` | (product[RW+NW-1:RW]!=0), `cnt`<=`cnt`-1, go to CHECK.
- DONE:
  - `done`=1, `result`<=`acc`, `overflow`<=`ovf`, go to IDLE.

Rules:
- Product width is RW+NW. Counter decrement never wraps, because CHECK exits at 1.
- `start` outside IDLE is ignored. It is not queued.
- `number` changes after the accepting edge have no effect.
- `result` and `overflow` keep their previous values during a computation.

## Timing
Reset values:
- `ready`=1, `done`=0, `result`=0, `overflow`=0.
- State IDLE, `acc`=1, `cnt`=0.

Latency and throughput:
- Take the accepting edge as cycle 0. `done` is high in cycle 2 + (NW+1)·max(N−1,0).
  - N=0 or N=1: cycle 2.
  - N=5: cycle 38.
  - N=255: cycle 2288.
- `ready` returns high in the cycle after `done`. The earliest next accept is that cycle, so back-to-back requests have one idle cycle between them.

Reset behaviour:
- A reset asserted mid-operation aborts the computation immediately and returns all outputs to their reset values.
- No `done` is produced for the aborted request.

## Configuration
Macro `FACT_SAT_EN`.
- Defined:
  - `ovf` is tracked.
  - While `ovf`=1, the multiplier result is discarded and `acc` is forced to all-ones. `result` is therefore 0xFFFFFFFF on overflow.
  - Latency is unchanged, because iterations still run.
- Not defined:
  - The overflow logic is removed and `overflow` is tied 0.
  - `result` is the product modulo 2^RW.

## Structure
Package `fact_pkg` holds:
- State enum: IDLE, CHECK, MUL, DONE.
- `NW` and `RW` defaults.
- Constant `FACT_SAT_VAL` (all-ones, RW bits).

Sub-module `fact_shift_mul`:
- Sequential shift-add multiplier, RW × NW into RW+NW bits.
- Ports: `clk`, `reset`, `load`, `a`, `b`, `busy`, `last`, `p`.
- Its bit counter is owned inside it. `fact_sequencer` instantiates it once.

## Test plan
- After reset with `start`=0: `ready`=1, `done`=0, `result`=0, `overflow`=0.
- `number`=0, then `number`=1 → `result`=1, `overflow`=0, `done` in cycle 2 each time.
- `number`=5 → `result`=120 (0x78), `done` exactly in cycle 38. Then `number`=12 → `result`=0x1C8CFC00, `overflow`=0.
- `number`=13 → with `FACT_SAT_EN`: `result`=0xFFFFFFFF, `overflow`=1. Without it: `result`=0x7328CC00, `overflow`=0.
- `number`=4 accepted, then `start` with `number`=9 pulsed in cycle 5 → ignored. Only `result`=24 is produced, at cycle 29.
- `number`=10 accepted, `reset` pulsed in cycle 15 → `ready`=1, `result`=0, no `done`. A following `number`=3 gives `result`=6.
